fp_cmp_arbiter: RTL and testbench
=================================

Name: fp_cmp_arbiter

Overview:
Shares one pipelined fp_cmp unit among NREQ independent requesters. Each requester presents an FP32 operand pair over a valid/ready handshake. The block grants the unit round-robin and drives the fp_cmp source-side ports. It tracks in-flight operations in a tag FIFO and steers each result back to its originating requester. It sits between the SFU issue logic and the fp_cmp datapath and owns that unit's enable and src_valid.

Parameters:
NREQ, 4, number of requesters (2..8)
CMP_LAT, 2, fp_cmp latency in enabled cycles from src_valid to dst_valid
MAX_INFLIGHT, 4, tag FIFO depth; maximum outstanding operations (>= CMP_LAT+1 gives full throughput)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
hold  in  1  global stall; freezes issue and the fp_cmp pipeline
req_valid  in  NREQ  per-requester operation valid
req_ready  out  NREQ  per-requester grant; transfer when valid&ready
req_a  in  NREQ*32  operand A per requester, packed {sign,exp[7:0],man[22:0]}, requester i at [32i+:32]
req_b  in  NREQ*32  operand B, same packing
cmp_enable  out  1  to fp_cmp enable
cmp_src_valid  out  1  to fp_cmp src_valid
cmp_a_man/cmp_a_exp/cmp_a_sign  out  23/8/1  to fp_cmp operand A
cmp_b_man/cmp_b_exp/cmp_b_sign  out  23/8/1  to fp_cmp operand B
cmp_r_man/cmp_r_exp/cmp_r_sign  in  23/8/1  from fp_cmp result
cmp_dst_valid  in  1  from fp_cmp result valid
rsp_valid  out  NREQ  one-hot result valid; no backpressure
rsp_data  out  32  result {sign,exp,man}, shared by all requesters
err_orphan  out  1  sticky; set when cmp_dst_valid arrives with the tag FIFO empty

Behaviour:
- Reset: all outputs go to 0 except cmp_enable, which goes to 1. Reset clears the RR pointer to requester 0, empties the tag FIFO (count=0), clears the issue register and err_orphan. Reset is asynchronous and may assert at any time; in-flight tags are discarded.
- cmp_enable = ~hold (combinational).
- issue_ok = ~hold & (count < MAX_INFLIGHT | pop_this_cycle).
- Arbitration: round-robin. The search starts at ptr, ptr+1, ... mod NREQ; the winner is the first i with req_valid[i]. req_ready[i] = issue_ok & (i==winner). req_ready is combinational and at most one bit is set. A requester must not depend on ready to raise valid.
- On transfer by requester i at cycle T:
  - the issue register captures req_a/req_b fields;
  - cmp_src_valid=1 at T+1;
  - tag i is pushed to the FIFO;
  - ptr becomes (i+1) mod NREQ.
- No transfer and ~hold: cmp_src_valid=0 next cycle. With hold=1, the issue register, cmp_src_valid, ptr and FIFO are frozen.
- Return path:
  - Pop occurs when cmp_dst_valid & cmp_enable & count>0.
  - At the next cycle, rsp_valid[tag]=1 for exactly one cycle and rsp_data={r_sign,r_exp,r_man}.
  - End-to-end latency with no hold: accept at T, rsp_valid at T+CMP_LAT+2.
- Orphan case: cmp_dst_valid & cmp_enable & count==0 sets err_orphan and produces no response. err_orphan clears only on rst.
- Simultaneous push and pop are allowed when full; count is unchanged and order is preserved (FIFO, in-order results).
- count width is clog2(MAX_INFLIGHT+1). Pointer and FIFO indices wrap modulo their depth.
- rsp_valid/rsp_data are registered; rsp_data holds its last value when rsp_valid=0.

Decomposition:
- Package fp_cmp_ctl_pkg contains:
  - FP32 field widths (MAN_W=23, EXP_W=8);
  - a packed fp32 struct with unpack/pack functions;
  - a clog2-based TAG_W function of NREQ.
- One sub-module, fp_cmp_tag_fifo: synchronous FIFO of TAG_W entries with depth MAX_INFLIGHT, push/pop/count/empty/full, and async active-high reset.
- The arbiter, issue register and response register stay in the top level.

Test Plan:
- Single request: req_valid=4'b0100 with A=0x3F800000, B=0x40000000 at T -> req_ready=4'b0100 at T; cmp_src_valid at T+1; rsp_valid=4'b0100 at T+4 with rsp_data equal to fp_cmp's output.
- All four valid continuously for 12 cycles from reset -> grants cycle 0,1,2,3,0,1,... one per cycle. rsp_valid order matches grant order, 4 cycles later.
- fp_cmp model with CMP_LAT=6, MAX_INFLIGHT=4, all requesters valid:
  - exactly 4 grants, then req_ready=0 until the first pop;
  - the first pop cycle also grants (simultaneous push/pop, count stays 4).
- hold=1 for 3 cycles with 2 ops in flight -> cmp_enable=0, req_ready=0, cmp_src_valid/FIFO frozen. Responses are delayed by exactly 3 cycles, with no loss or duplication.
- rst asserted mid-stream with 3 in flight, then fp_cmp emits a stale cmp_dst_valid -> err_orphan=1, rsp_valid stays 0, ptr restarts at requester 0.
- Requester 2 only, then requesters 1 and 3 together -> after granting 2, the next grant goes to 3 (ptr=3), then to 1.

Source files
------------

// File: rtl/fp_cmp_ctl_pkg.sv
// Shared types and helpers for the fp_cmp request arbiter.
// FP32 field layout and tag sizing live here.
package fp_cmp_ctl_pkg;

  localparam int MAN_W = 23;
  localparam int EXP_W = 8;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  function automatic fp32_t fp_unpack(input logic [31:0] w);
    return fp32_t'(w);
  endfunction

  function automatic logic [31:0] fp_pack(input fp32_t f);
    return 32'(f);
  endfunction

  function automatic int tag_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fp_cmp_tag_fifo.sv
// In-flight tag FIFO for the fp_cmp arbiter.
// Push and pop may coincide, including when full.
module fp_cmp_tag_fifo #(
  parameter  int W     = 2,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_tag,
  input  logic          pop,
  output logic [W-1:0]  pop_tag,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign pop_tag = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_tag;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + CW'(1);
      else if (do_pop && !do_push)
        count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/fp_cmp_arbiter.sv
// Round-robin share of one pipelined fp_cmp among NREQ requesters.
// Results return in order and are steered back by a tag FIFO.
module fp_cmp_arbiter
  import fp_cmp_ctl_pkg::*;
#(
  parameter int NREQ         = 4,
  parameter int CMP_LAT      = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic              cmp_enable,
  output logic              cmp_src_valid,
  output logic [MAN_W-1:0]  cmp_a_man,
  output logic [EXP_W-1:0]  cmp_a_exp,
  output logic              cmp_a_sign,
  output logic [MAN_W-1:0]  cmp_b_man,
  output logic [EXP_W-1:0]  cmp_b_exp,
  output logic              cmp_b_sign,
  input  logic [MAN_W-1:0]  cmp_r_man,
  input  logic [EXP_W-1:0]  cmp_r_exp,
  input  logic              cmp_r_sign,
  input  logic              cmp_dst_valid,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              err_orphan
);

  localparam int TW = tag_w(NREQ);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  if (CMP_LAT < 1) begin : g_bad_lat
    $error("CMP_LAT must be at least 1");
  end
  if (MAX_INFLIGHT < 1) begin : g_bad_depth
    $error("MAX_INFLIGHT must be at least 1");
  end

  logic [TW-1:0] ptr;
  logic [TW-1:0] winner;
  logic          found;
  logic          issue_ok;
  logic          xfer;
  logic          pop;
  logic          orphan;
  logic [TW-1:0] pop_tag;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic [31:0]   sel_a;
  logic [31:0]   sel_b;
  fp32_t         a_q;
  fp32_t         b_q;
  fp32_t         rsp_q;
  int            idx;

  assign cmp_enable = ~hold;
  assign pop        = cmp_dst_valid & cmp_enable & ~empty;
  assign orphan     = cmp_dst_valid & cmp_enable & (count == '0);
  assign issue_ok   = ~rst & ~hold & (~full | pop);
  assign xfer       = issue_ok & found;
  assign req_ready  = xfer ? (NREQ'(1) << winner) : '0;

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = TW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner == TW'(i)) begin
        sel_a = req_a[32*i +: 32];
        sel_b = req_b[32*i +: 32];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr           <= '0;
      cmp_src_valid <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
    end else if (!hold) begin
      cmp_src_valid <= xfer;
      if (xfer) begin
        a_q <= fp_unpack(sel_a);
        b_q <= fp_unpack(sel_b);
        ptr <= (winner == TW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
    end
  end

  assign cmp_a_sign = a_q.sign;
  assign cmp_a_exp  = a_q.exp;
  assign cmp_a_man  = a_q.man;
  assign cmp_b_sign = b_q.sign;
  assign cmp_b_exp  = b_q.exp;
  assign cmp_b_man  = b_q.man;

  fp_cmp_tag_fifo #(
    .W     (TW),
    .DEPTH (MAX_INFLIGHT)
  ) u_tags (
    .clk      (clk),
    .rst      (rst),
    .push     (xfer),
    .push_tag (winner),
    .pop      (pop),
    .pop_tag  (pop_tag),
    .count    (count),
    .empty    (empty),
    .full     (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid  <= '0;
      rsp_q      <= '0;
      err_orphan <= 1'b0;
    end else begin
      rsp_valid <= pop ? (NREQ'(1) << pop_tag) : '0;
      if (pop) rsp_q <= '{sign: cmp_r_sign, exp: cmp_r_exp, man: cmp_r_man};
      if (orphan) err_orphan <= 1'b1;
    end
  end

  assign rsp_data = fp_pack(rsp_q);

endmodule

// File: tb/tb_fp_cmp_arbiter.sv
// Randomized bench for fp_cmp_arbiter with a pipelined fp_cmp stand-in.
// A queue-based reference model predicts grants, responses and errors.
module tb_fp_cmp_arbiter;
  import fp_cmp_ctl_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXI = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic              cmp_enable;
  logic              cmp_src_valid;
  logic [MAN_W-1:0]  cmp_a_man;
  logic [EXP_W-1:0]  cmp_a_exp;
  logic              cmp_a_sign;
  logic [MAN_W-1:0]  cmp_b_man;
  logic [EXP_W-1:0]  cmp_b_exp;
  logic              cmp_b_sign;
  logic [MAN_W-1:0]  cmp_r_man;
  logic [EXP_W-1:0]  cmp_r_exp;
  logic              cmp_r_sign;
  logic              cmp_dst_valid;
  logic [NREQ-1:0]   rsp_valid;
  logic [31:0]       rsp_data;
  logic              err_orphan;

  always #5 clk = ~clk;

  fp_cmp_arbiter #(
    .NREQ         (NREQ),
    .CMP_LAT      (2),
    .MAX_INFLIGHT (MAXI)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hold          (hold),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .cmp_enable    (cmp_enable),
    .cmp_src_valid (cmp_src_valid),
    .cmp_a_man     (cmp_a_man),
    .cmp_a_exp     (cmp_a_exp),
    .cmp_a_sign    (cmp_a_sign),
    .cmp_b_man     (cmp_b_man),
    .cmp_b_exp     (cmp_b_exp),
    .cmp_b_sign    (cmp_b_sign),
    .cmp_r_man     (cmp_r_man),
    .cmp_r_exp     (cmp_r_exp),
    .cmp_r_sign    (cmp_r_sign),
    .cmp_dst_valid (cmp_dst_valid),
    .rsp_valid     (rsp_valid),
    .rsp_data      (rsp_data),
    .err_orphan    (err_orphan)
  );

  function automatic logic [31:0] cmp_fn(input logic [31:0] a, input logic [31:0] b);
    return a + {b[30:0], 1'b0};
  endfunction

  // fp_cmp stand-in: variable-latency pipeline advancing on enable, never reset
  int          lat = 2;
  logic        pv [16];
  logic [31:0] pd [16];

  initial begin
    for (int k = 0; k < 16; k++) begin
      pv[k] = 1'b0;
      pd[k] = '0;
    end
  end

  always @(posedge clk) begin
    if (cmp_enable) begin
      for (int k = 15; k > 0; k--) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
      pv[0] <= cmp_src_valid;
      pd[0] <= cmp_fn({cmp_a_sign, cmp_a_exp, cmp_a_man},
                      {cmp_b_sign, cmp_b_exp, cmp_b_man});
    end
  end

  assign cmp_dst_valid = pv[lat-1];
  assign {cmp_r_sign, cmp_r_exp, cmp_r_man} = pd[lat-1];

  typedef struct {
    int          req;
    logic [31:0] a;
    logic [31:0] b;
    int          age;
  } op_t;

  op_t             sb[$];
  int              mptr;
  logic            exp_src;
  logic [31:0]     exp_a;
  logic [31:0]     exp_b;
  logic [NREQ-1:0] exp_rsp;
  logic [31:0]     exp_data;
  logic            exp_err;
  int              checks = 0;
  int              errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic model_reset();
    mptr     = 0;
    sb.delete();
    exp_src  = 1'b0;
    exp_a    = '0;
    exp_b    = '0;
    exp_rsp  = '0;
    exp_data = '0;
    exp_err  = 1'b0;
  endtask

  task automatic evaluate();
    logic            pop;
    logic            orphan;
    logic            ok;
    logic            xfer;
    logic [NREQ-1:0] exp_ready;
    int              win;
    int              best;
    int              d;
    op_t             f;
    op_t             n;
    if (rst) begin
      chk("rst_ready", 32'(req_ready), 32'(0));
      chk("rst_src_valid", 32'(cmp_src_valid), 32'(0));
      chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_rsp_data", rsp_data, 32'(0));
      chk("rst_err", 32'(err_orphan), 32'(0));
      chk("rst_enable", 32'(cmp_enable), 32'(1));
      chk("rst_src_a", {cmp_a_sign, cmp_a_exp, cmp_a_man}, 32'(0));
      model_reset();
      return;
    end
    chk("enable", 32'(cmp_enable), 32'(!hold));
    chk("src_valid", 32'(cmp_src_valid), 32'(exp_src));
    chk("src_a", {cmp_a_sign, cmp_a_exp, cmp_a_man}, exp_a);
    chk("src_b", {cmp_b_sign, cmp_b_exp, cmp_b_man}, exp_b);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
    chk("rsp_data", rsp_data, exp_data);
    chk("err_orphan", 32'(err_orphan), 32'(exp_err));
    pop    = cmp_dst_valid && !hold && sb.size() > 0;
    orphan = cmp_dst_valid && !hold && sb.size() == 0;
    ok     = !hold && (sb.size() < MAXI || pop);
    win    = -1;
    best   = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        d = (i - mptr + NREQ) % NREQ;
        if (d < best) begin
          best = d;
          win  = i;
        end
      end
    end
    xfer      = ok && win >= 0;
    exp_ready = xfer ? NREQ'(1 << win) : '0;
    chk("req_ready", 32'(req_ready), 32'(exp_ready));
    exp_rsp = '0;
    if (pop) begin
      f = sb.pop_front();
      chk("latency", 32'(f.age), 32'(lat));
      exp_rsp  = NREQ'(1 << f.req);
      exp_data = cmp_fn(f.a, f.b);
    end
    if (!hold) begin
      foreach (sb[k]) sb[k].age++;
      exp_src = xfer;
    end
    if (xfer) begin
      n.req = win;
      n.a   = req_a[32*win +: 32];
      n.b   = req_b[32*win +: 32];
      n.age = 0;
      sb.push_back(n);
      exp_a = n.a;
      exp_b = n.b;
      mptr  = (win + 1) % NREQ;
    end
    if (orphan) exp_err = 1'b1;
  endtask

  task automatic cyc(input logic [NREQ-1:0] v, input logic h, input logic r,
                     input bit fix = 1'b0, input logic [31:0] fa = '0,
                     input logic [31:0] fb = '0);
    @(posedge clk);
    #1;
    rst       = r;
    hold      = h;
    req_valid = v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[32*i +: 32] = fix ? fa : $urandom;
      req_b[32*i +: 32] = fix ? fb : $urandom;
    end
    #4;
    evaluate();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc('0, 1'b0, 1'b0);
  endtask

  initial begin
    rst       = 1'b1;
    hold      = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    model_reset();
    cyc('0, 1'b0, 1'b1);
    cyc('0, 1'b0, 1'b1);
    cyc(4'b0100, 1'b0, 1'b0, 1'b1, 32'h3F80_0000, 32'h4000_0000);
    idle(6);
    repeat (12) cyc('1, 1'b0, 1'b0);
    idle(8);
    cyc(4'b0100, 1'b0, 1'b0);
    cyc(4'b1010, 1'b0, 1'b0);
    cyc(4'b0010, 1'b0, 1'b0);
    idle(6);
    cyc('1, 1'b0, 1'b0);
    cyc('1, 1'b0, 1'b0);
    repeat (3) cyc('1, 1'b1, 1'b0);
    idle(10);
    lat = 6;
    repeat (20) cyc('1, 1'b0, 1'b0);
    idle(12);
    for (int p = 0; p < 4; p++) begin
      lat = (p % 2 == 0) ? 2 : 6;
      repeat (200) cyc(NREQ'($urandom), ($urandom_range(0, 4) == 0), 1'b0);
      idle(14);
    end
    lat = 6;
    repeat (3) cyc('1, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b0);
    cyc('0, 1'b0, 1'b1);
    idle(14);
    repeat (6) cyc('1, 1'b0, 1'b0);
    idle(14);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
